// File: rtl/uart_pwm_pkg.sv
// Shared definitions for the UART transmit path.
//   arb_state_e    : arbiter FSM state encoding
//   DATA_W_DEFAULT : default byte width of the uart_tx data port
//   rr_wrap_inc    : index increment with wrap to 0 at n-1
package uart_pwm_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } arb_state_e;

  function automatic int rr_wrap_inc(input int idx, input int n);
    if (idx >= n - 1) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req_i    : request vector
//   ptr_i    : index holding the highest priority this round
//   onehot_o : one-hot winner (0 when no request)
//   idx_o    : winner index
//   any_o    : at least one request present
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Two passes: first the requests at or above ptr_i, then wrap to the lowest index.
  always_comb begin : pick_scan
    logic hit;
    hit      = 1'b0;
    onehot_o = {N_REQ{1'b0}};
    idx_o    = {IDX_W{1'b0}};
    any_o    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      hit         = req_i[i] && (IDX_W'(i) >= ptr_i) && !any_o;
      onehot_o[i] = onehot_o[i] | hit;
      idx_o       = hit ? IDX_W'(i) : idx_o;
      any_o       = any_o | hit;
    end
    for (int i = 0; i < N_REQ; i++) begin
      hit         = req_i[i] && !any_o;
      onehot_o[i] = onehot_o[i] | hit;
      idx_o       = hit ? IDX_W'(i) : idx_o;
      any_o       = any_o | hit;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte sources.
// A winner keeps the transmitter until it sends a byte flagged last; each
// byte is launched exactly once, never while the UART reports busy.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   req_i         : requester i holds a valid byte
//   req_data_i    : byte i at [i*DATA_W +: DATA_W]
//   req_last_i    : byte i ends its message
//   req_ack_o     : one-cycle accept pulse, coincident with tx_start_o
//   grant_o       : one-hot current owner
//   tx_start_o    : launch pulse to uart_tx
//   tx_data_o     : byte to uart_tx, held until next launch
//   tx_busy_i     : uart_tx busy flag
//   locked_o      : message in progress, owner retained
//   err_to_o      : sticky, tx_busy_i never rose after a launch
module uart_tx_arbiter
  import uart_pwm_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int BUSY_TO = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ack_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    tx_start_o,
  output logic [DATA_W-1:0]       tx_data_o,
  input  logic                    tx_busy_i,
  output logic                    locked_o,
  output logic                    err_to_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  req_ack_q, req_ack_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic              last_q, last_d;
  logic              locked_q, locked_d;
  logic              err_to_q, err_to_d;
  logic              tx_start_q, tx_start_d;

  logic [N_REQ-1:0]  pick_onehot_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              pick_any_s;
  logic [N_REQ-1:0]  sel_onehot_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic              sel_any_s;
  logic [DATA_W-1:0] req_bytes_s [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign req_bytes_s[gi] = req_data_i[gi*DATA_W +: DATA_W];
  end

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot_s),
    .idx_o    (pick_idx_s),
    .any_o    (pick_any_s)
  );

  // While a message is locked only the owner is eligible; otherwise round-robin.
  always_comb begin
    sel_onehot_s = pick_onehot_s;
    sel_idx_s    = pick_idx_s;
    sel_any_s    = pick_any_s;
    if (locked_q) begin
      sel_onehot_s = grant_q;
      sel_idx_s    = owner_q;
      sel_any_s    = req_i[owner_q];
    end else begin
      sel_any_s    = pick_any_s;
    end
  end

  // Next-state and next-output logic of the launch sequencer.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    to_cnt_d   = to_cnt_q;
    last_d     = last_q;
    locked_d   = locked_q;
    err_to_d   = err_to_q;
    tx_start_d = 1'b0;
    req_ack_d  = {N_REQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (locked_q && !req_i[owner_q]) begin
          // Owner walked away mid-message: release and pass priority on.
          locked_d = 1'b0;
          grant_d  = {N_REQ{1'b0}};
          rr_ptr_d = IDX_W'(rr_wrap_inc(int'(owner_q), N_REQ));
        end else if (!tx_busy_i && sel_any_s) begin
          owner_d    = sel_idx_s;
          grant_d    = sel_onehot_s;
          tx_data_d  = req_bytes_s[sel_idx_s];
          last_d     = req_last_i[sel_idx_s];
          tx_start_d = 1'b1;
          req_ack_d  = sel_onehot_s;
          state_d    = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        locked_d = !last_q;
        to_cnt_d = {CNT_W{1'b0}};
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_IDLE;
        end else if (to_cnt_q == CNT_W'(BUSY_TO - 1)) begin
          // UART never acknowledged: flag it, drop the byte, release the owner.
          err_to_d = 1'b1;
          locked_d = 1'b0;
          grant_d  = {N_REQ{1'b0}};
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (!tx_busy_i) begin
          if (last_q) begin
            rr_ptr_d = IDX_W'(rr_wrap_inc(int'(owner_q), N_REQ));
            grant_d  = {N_REQ{1'b0}};
          end else begin
            grant_d  = grant_q;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        locked_d = 1'b0;
        grant_d  = {N_REQ{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= {IDX_W{1'b0}};
      rr_ptr_q   <= {IDX_W{1'b0}};
      grant_q    <= {N_REQ{1'b0}};
      req_ack_q  <= {N_REQ{1'b0}};
      tx_data_q  <= {DATA_W{1'b0}};
      to_cnt_q   <= {CNT_W{1'b0}};
      last_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_to_q   <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      req_ack_q  <= req_ack_d;
      tx_data_q  <= tx_data_d;
      to_cnt_q   <= to_cnt_d;
      last_q     <= last_d;
      locked_q   <= locked_d;
      err_to_q   <= err_to_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign req_ack_o  = req_ack_q;
  assign grant_o    = grant_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign locked_o   = locked_q;
  assign err_to_o   = err_to_q;

endmodule
